// File: rtl/truth_table_checker.sv
// truth_table_checker: clocked exhaustive sweep of a single-output
// combinational block. Drives every input vector in ascending order, holds
// each for SETTLE cycles, samples the DUT output for one cycle and compares
// it against the TRUTH table. Counts mismatches and records the first one.
module truth_table_checker #(
    parameter int                      N_IN         = 3,
    parameter logic [(1<<N_IN)-1:0]    TRUTH        = 8'b0000_0001,
    parameter int                      SETTLE       = 2,
    parameter bit                      STOP_ON_FAIL = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dut_f,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_count,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_valid
);

    // Settle counter only has to reach SETTLE.
    localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [N_IN-1:0] LAST = '1;

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            mismatch;

    assign mismatch = (dut_f != TRUTH[stim]);

    // pass is a pure function of the registered done flag and the count.
    assign pass = done && (fail_count == '0);

    // Sweep sequencer; every output except pass is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            stim             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            fail_count       <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        fail_count       <= '0;
                        first_fail       <= '0;
                        first_fail_valid <= 1'b0;
                        done             <= 1'b0;
                        stim             <= '0;
                        cnt              <= '0;
                        busy             <= 1'b1;
                        state            <= WAIT;
                    end
                end
                WAIT: begin
                    // Stimulus held; leave after SETTLE cycles here.
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(SETTLE - 1))
                        state <= CHECK;
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_count <= fail_count + 1'b1;
                        if (!first_fail_valid) begin
                            first_fail       <= stim;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    // Stop leaves stim on the failing or final vector.
                    if ((mismatch && STOP_ON_FAIL) || (stim == LAST)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        stim  <= stim + 1'b1;
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
